softmax_seq_ctrl: RTL and testbench
===================================

Name: softmax_seq_ctrl

Overview:
- Sequencer that drives the softmax datapath's add_inst/inst control fields (mode, lut_wr, execute, fetch, qmem_rd, qkmem_add) from a single start command.
- Replaces hand-timed bench stimulus with a fixed, parameterised schedule:
  - optional four-phase LUT load from Q-memory;
  - execute;
  - in GSA mode, a wait followed by a fetch window.
- Sits between the top-level command interface and fullchip.

Parameters:
- LUT_SETTLE, 8, idle cycles after each lut_wr pulse; 0 is legal.
- EXEC_WAIT, 30, GSA cycles between the execute pulse and fetch start; 0 is legal.
- FETCH_LEN, 40, GSA cycles fetch is held high; must be >= 1.
- LSA_EXEC_LEN, 41, LSA cycles execute is held high; must be >= 1.
- CNT_W, 8, internal down-counter width; must hold max(all lengths).
- ADDR_W, 6, qkmem_add width.

Ports:
- clk, input, 1, clock, rising edge.
- reset, input, 1, asynchronous active-high reset.
- start, input, 1, one-cycle command strobe.
- start_mode, input, 2, 0 = LSA (8 inputs), 1 = GSA (8x8), 2 and 3 reserved.
- start_lut, input, 1, 1 = run the LUT load before execute.
- abort, input, 1, synchronous cancel.
- mode, output, 2, mode latched at accepted start.
- lut_wr, output, 2, 0 none, 1 LSB LUT write, 2 MSB LUT write.
- qmem_rd, output, 1, Q-memory read enable.
- qkmem_add, output, ADDR_W, Q-memory address.
- execute, output, 1, datapath execute.
- fetch, output, 1, psum fetch.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle completion pulse.
- err, output, 1, one-cycle pulse when a start is rejected.

Behaviour:
- Reset (async): state IDLE; all outputs 0, including mode. Counters and phase index are cleared.
- Outputs are decoded from registered state, counter and phase only; there are no combinational paths from inputs to outputs.
- States: IDLE, LUT_ADDR, LUT_WR, LUT_SETTLE, EXEC, EXEC_WAIT, FETCH, DONE.
- Start acceptance:
  - Accepted only in IDLE with start=1 and start_mode[1]=0.
  - On acceptance, mode <= start_mode and is held until the next accepted start.
  - Next state is LUT_ADDR with phase 0 if start_lut=1, otherwise EXEC.
- Start rejection:
  - start in IDLE with start_mode[1]=1: err=1 the next cycle, stay in IDLE, mode unchanged.
  - start while busy is ignored; no err.
- LUT phase table: phase p selects (address, lut_wr code) = (1,1), (0,1), (3,2), (2,2).
  - LUT_ADDR (1 cycle): qmem_rd=1, qkmem_add=addr[p], lut_wr=0.
  - LUT_WR (1 cycle): qmem_rd=1, qkmem_add=addr[p], lut_wr=code[p].
  - LUT_SETTLE (LUT_SETTLE cycles, skipped if 0): qmem_rd=1, address held, lut_wr=0.
  - After phase 3 go to EXEC, otherwise to LUT_ADDR with p+1. Each phase takes 2+LUT_SETTLE cycles.
- qmem_rd and qkmem_add are 0 in all non-LUT states.
- EXEC, GSA (mode=1): execute=1 for exactly 1 cycle, then EXEC_WAIT (EXEC_WAIT cycles, skipped if 0), then FETCH.
- FETCH: fetch=1 for FETCH_LEN cycles, then DONE.
- EXEC, LSA (mode=0): execute=1 for LSA_EXEC_LEN consecutive cycles, then DONE. fetch is never asserted.
- DONE (1 cycle): done=1 and busy=1; next state IDLE.
- Timeline, cycle n = n-th cycle after the accepting edge, defaults:
  - GSA with LUT load: LUT cycles 1-40, execute cycle 41, fetch cycles 72-111, done cycle 112.
  - GSA without LUT load: execute cycle 1, done cycle 72.
  - LSA with LUT load: execute cycles 41-81, done cycle 82.
- abort in any non-IDLE state: next cycle is IDLE with all strobes 0, no done, mode retained. abort in IDLE has no effect. If abort and start are both high in IDLE, start is accepted.
- Reset asserted mid-operation: all outputs are forced to 0 immediately (asynchronously).
- Counters load length-1 on state entry and decrement to 0. No wrap-around is possible because lengths are checked at elaboration.

Decomposition:
- Shared package softmax_ctrl_pkg holds:
  - state enum;
  - LUT phase table constants LUT_ADDR_TBL = {1,0,3,2} and LUT_CODE_TBL = {1,1,2,2};
  - lut_wr codes LUT_NONE/LUT_LSB/LUT_MSB;
  - mode codes MODE_LSA/MODE_GSA.
- One sub-module, softmax_ctrl_cnt: a loadable down-counter with load, value and zero flag, reused for settle, wait, fetch and LSA execute lengths.

Test Plan:
- Reset, then hold 5 cycles -> all outputs 0 and busy=0. Assert reset mid-FETCH -> fetch drops to 0 before the next clock edge.
- start with start_mode=1, start_lut=1 ->
  - qkmem_add=1/0/3/2 with lut_wr=1 at cycles 2, 12 and lut_wr=2 at cycles 22, 32;
  - qmem_rd=1 for cycles 1-40;
  - execute at cycle 41 only, fetch cycles 72-111, done at 112.
- start with start_mode=0, start_lut=0 -> execute=1 cycles 1-41, fetch never 1, done at 42, mode=0.
- start pulsed again at cycle 50 of a GSA run -> ignored, schedule unchanged, err=0. start with start_mode=2 in IDLE -> err pulse, busy stays 0.
- abort at fetch cycle 80 -> IDLE at cycle 81 with fetch=0, no done pulse. A following start runs a full schedule from cycle 1.
- Parameter override LUT_SETTLE=0, EXEC_WAIT=0 with GSA and LUT load -> lut_wr at cycles 2, 4, 6, 8; execute at 9; fetch 10-49; done at 50.

Source files
------------

// File: rtl/softmax_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// softmax_ctrl_pkg : shared types and constants for the softmax sequencer.
// Revision: 1.0
// ============================================================================
package softmax_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LUT_ADDR   = 3'd1,
    ST_LUT_WR     = 3'd2,
    ST_LUT_SETTLE = 3'd3,
    ST_EXEC       = 3'd4,
    ST_EXEC_WAIT  = 3'd5,
    ST_FETCH      = 3'd6,
    ST_DONE       = 3'd7
  } state_t;

  localparam logic [1:0] LUT_NONE = 2'd0;
  localparam logic [1:0] LUT_LSB  = 2'd1;
  localparam logic [1:0] LUT_MSB  = 2'd2;

  localparam logic [1:0] MODE_LSA = 2'd0;
  localparam logic [1:0] MODE_GSA = 2'd1;

  // Phase p loads LUT half code[p] from Q-memory word addr[p]
  localparam logic [1:0] LUT_ADDR_TBL [4] = '{2'd1, 2'd0, 2'd3, 2'd2};
  localparam logic [1:0] LUT_CODE_TBL [4] = '{LUT_LSB, LUT_LSB, LUT_MSB, LUT_MSB};

endpackage
`default_nettype wire

// File: rtl/softmax_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// softmax_seq_ctrl_if : command strobes in, datapath control fields out.
// Revision: 1.0
// ============================================================================
interface softmax_seq_ctrl_if #(
  parameter int ADDR_W = 6
);
  logic              start;
  logic [1:0]        start_mode;
  logic              start_lut;
  logic              abort;

  logic [1:0]        mode;
  logic [1:0]        lut_wr;
  logic              qmem_rd;
  logic [ADDR_W-1:0] qkmem_add;
  logic              execute;
  logic              fetch;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, start_mode, start_lut, abort,
    input  mode, lut_wr, qmem_rd, qkmem_add, execute, fetch, busy, done, err
  );

  modport slave (
    input  start, start_mode, start_lut, abort,
    output mode, lut_wr, qmem_rd, qkmem_add, execute, fetch, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/softmax_ctrl_cnt.sv
`default_nettype none
// ============================================================================
// softmax_ctrl_cnt : loadable down-counter with value and zero flag.
// Revision: 1.0
// ============================================================================
module softmax_ctrl_cnt #(
  parameter int CNT_W = 8
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             i_load,
  input  wire logic [CNT_W-1:0] i_load_val,
  input  wire logic             i_dec,
  output logic      [CNT_W-1:0] o_val,
  output logic                  o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_val  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/softmax_seq_ctrl.sv
`default_nettype none
// ============================================================================
// softmax_seq_ctrl : runs LUT load / execute / fetch schedule from one start.
// Revision: 1.0
// ============================================================================
module softmax_seq_ctrl
  import softmax_ctrl_pkg::*;
#(
  parameter int LUT_SETTLE   = 8,
  parameter int EXEC_WAIT    = 30,
  parameter int FETCH_LEN    = 40,
  parameter int LSA_EXEC_LEN = 41,
  parameter int CNT_W        = 8,
  parameter int ADDR_W       = 6
) (
  input wire logic             clk,
  input wire logic             reset,
  softmax_seq_ctrl_if.slave    bus
);

  if (LUT_SETTLE < 0 || EXEC_WAIT < 0 || FETCH_LEN < 1 || LSA_EXEC_LEN < 1 ||
      LUT_SETTLE > 2**CNT_W || EXEC_WAIT > 2**CNT_W ||
      FETCH_LEN > 2**CNT_W || LSA_EXEC_LEN > 2**CNT_W) begin : g_bad_params
    $error("softmax_seq_ctrl: length parameter out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] c_settle_ld = (LUT_SETTLE > 0) ? CNT_W'(LUT_SETTLE - 1) : '0;
  localparam logic [CNT_W-1:0] c_wait_ld   = (EXEC_WAIT > 0)  ? CNT_W'(EXEC_WAIT - 1)  : '0;
  localparam logic [CNT_W-1:0] c_fetch_ld  = CNT_W'(FETCH_LEN - 1);
  localparam logic [CNT_W-1:0] c_lsa_ld    = CNT_W'(LSA_EXEC_LEN - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_phase;
  logic [1:0]       w_phase_nxt;
  logic [1:0]       r_mode;
  logic             r_err;
  logic             w_accept;
  logic             w_reject;
  logic             w_cnt_load;
  logic [CNT_W-1:0] w_cnt_ld_val;
  logic             w_cnt_dec;
  logic [CNT_W-1:0] w_cnt_cur;
  logic             w_cnt_zero;
  logic             w_lut_state;

  softmax_ctrl_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_ld_val),
    .i_dec      (w_cnt_dec),
    .o_val      (w_cnt_cur),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_phase <= 2'd0;
      r_mode  <= MODE_LSA;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_err   <= w_reject;
      if (w_accept) begin
        r_mode <= bus.start_mode;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_phase_nxt  = r_phase;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    w_cnt_load   = 1'b0;
    w_cnt_ld_val = '0;
    // Load takes priority inside the counter; a stale value outside counted states is harmless
    w_cnt_dec    = (w_cnt_cur != '0);

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          if (!bus.start_mode[1]) begin
            w_accept = 1'b1;
            if (bus.start_lut) begin
              w_state_nxt = ST_LUT_ADDR;
              w_phase_nxt = 2'd0;
            end else begin
              w_state_nxt  = ST_EXEC;
              w_cnt_load   = 1'b1;
              w_cnt_ld_val = (bus.start_mode == MODE_LSA) ? c_lsa_ld : '0;
            end
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      ST_LUT_ADDR: w_state_nxt = ST_LUT_WR;
      ST_LUT_WR, ST_LUT_SETTLE: begin
        if (r_state == ST_LUT_WR && LUT_SETTLE > 0) begin
          w_state_nxt  = ST_LUT_SETTLE;
          w_cnt_load   = 1'b1;
          w_cnt_ld_val = c_settle_ld;
        end else if (r_state == ST_LUT_SETTLE && !w_cnt_zero) begin
          w_state_nxt = ST_LUT_SETTLE;
        end else if (r_phase == 2'd3) begin
          w_state_nxt  = ST_EXEC;
          w_cnt_load   = 1'b1;
          w_cnt_ld_val = (r_mode == MODE_LSA) ? c_lsa_ld : '0;
        end else begin
          w_state_nxt = ST_LUT_ADDR;
          w_phase_nxt = r_phase + 2'd1;
        end
      end
      ST_EXEC: begin
        if (r_mode == MODE_GSA) begin
          w_cnt_load = 1'b1;
          if (EXEC_WAIT > 0) begin
            w_state_nxt  = ST_EXEC_WAIT;
            w_cnt_ld_val = c_wait_ld;
          end else begin
            w_state_nxt  = ST_FETCH;
            w_cnt_ld_val = c_fetch_ld;
          end
        end else if (w_cnt_zero) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_EXEC_WAIT: begin
        if (w_cnt_zero) begin
          w_state_nxt  = ST_FETCH;
          w_cnt_load   = 1'b1;
          w_cnt_ld_val = c_fetch_ld;
        end
      end
      ST_FETCH: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase

    if (bus.abort && r_state != ST_IDLE) begin
      w_state_nxt = ST_IDLE;
      w_cnt_load  = 1'b0;
    end
  end

  assign w_lut_state = (r_state == ST_LUT_ADDR) || (r_state == ST_LUT_WR) ||
                       (r_state == ST_LUT_SETTLE);

  assign bus.mode      = r_mode;
  assign bus.qmem_rd   = w_lut_state;
  assign bus.qkmem_add = w_lut_state ? ADDR_W'(LUT_ADDR_TBL[r_phase]) : '0;
  assign bus.lut_wr    = (r_state == ST_LUT_WR) ? LUT_CODE_TBL[r_phase] : LUT_NONE;
  assign bus.execute   = (r_state == ST_EXEC);
  assign bus.fetch     = (r_state == ST_FETCH);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done      = (r_state == ST_DONE);
  assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_softmax_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_softmax_seq_ctrl : default and zero-settle/zero-wait instances, same stimulus.
// Revision: 1.0
// ============================================================================
module tb_softmax_seq_ctrl;

  localparam int ADDR_W = 6;
  localparam int FLEN   = 40;
  localparam int ELEN   = 41;
  localparam int NONE   = 100000;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [1:0] last_mode;

  always #5 clk = ~clk;

  softmax_seq_ctrl_if #(.ADDR_W(ADDR_W)) bus_a ();
  softmax_seq_ctrl_if #(.ADDR_W(ADDR_W)) bus_b ();

  softmax_seq_ctrl #(
    .LUT_SETTLE(8), .EXEC_WAIT(30), .FETCH_LEN(FLEN), .LSA_EXEC_LEN(ELEN),
    .CNT_W(8), .ADDR_W(ADDR_W)
  ) u_dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));

  softmax_seq_ctrl #(
    .LUT_SETTLE(0), .EXEC_WAIT(0), .FETCH_LEN(FLEN), .LSA_EXEC_LEN(ELEN),
    .CNT_W(8), .ADDR_W(ADDR_W)
  ) u_dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

  // {busy, done, err, execute, fetch, qmem_rd, lut_wr[1:0], qkmem_add[5:0], mode[1:0]}
  logic [15:0] w_obs_a;
  logic [15:0] w_obs_b;
  assign w_obs_a = {bus_a.busy, bus_a.done, bus_a.err, bus_a.execute, bus_a.fetch,
                    bus_a.qmem_rd, bus_a.lut_wr, bus_a.qkmem_add, bus_a.mode};
  assign w_obs_b = {bus_b.busy, bus_b.done, bus_b.err, bus_b.execute, bus_b.fetch,
                    bus_b.qmem_rd, bus_b.lut_wr, bus_b.qkmem_add, bus_b.mode};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [1:0] sm, input logic sl, input logic ab);
    bus_a.start = st; bus_a.start_mode = sm; bus_a.start_lut = sl; bus_a.abort = ab;
    bus_b.start = st; bus_b.start_mode = sm; bus_b.start_lut = sl; bus_b.abort = ab;
  endtask

  function automatic int done_cyc(input logic [1:0] m, input bit lut, input int s, input int w);
    int l;
    l = lut ? 4 * (2 + s) : 0;
    return (m == 2'd1) ? l + w + FLEN + 2 : l + ELEN + 1;
  endfunction

  // Expected outputs in cycle n after the accepting edge, from the schedule rules
  function automatic logic [15:0] exp_vec(input int n, input logic [1:0] m, input bit lut,
                                          input int s, input int w);
    logic [15:0] v;
    logic [1:0]  addr_tbl [4];
    int per, l, d, p, off;
    addr_tbl = '{2'd1, 2'd0, 2'd3, 2'd2};
    per = 2 + s;
    l   = lut ? 4 * per : 0;
    d   = done_cyc(m, lut, s, w);
    v   = 16'h0;
    v[1:0] = m;
    v[15]  = (n >= 1 && n <= d);
    v[14]  = (n == d);
    if (n >= 1 && n <= l) begin
      p   = (n - 1) / per;
      off = (n - 1) % per;
      v[10]  = 1'b1;
      v[7:2] = {4'b0, addr_tbl[p]};
      if (off == 1) v[9:8] = (p < 2) ? 2'd1 : 2'd2;
    end
    if (m == 2'd1) begin
      v[12] = (n == l + 1);
      v[11] = (n >= l + 2 + w && n <= l + 1 + w + FLEN);
    end else begin
      v[12] = (n > l && n <= l + ELEN);
    end
    return v;
  endfunction

  task automatic run_seq(input logic [1:0] m, input bit lut, input int abort_at, input int restart_at);
    int da, db, len;
    logic [15:0] ea, eb, idle_v;
    da  = done_cyc(m, lut, 8, 30);
    db  = done_cyc(m, lut, 0, 0);
    len = ((da > db) ? da : db) + 2;
    idle_v = {14'b0, m};
    @(negedge clk);
    drive(1'b1, m, lut, 1'b0);
    @(posedge clk);
    #1 drive(1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
    for (int n = 1; n <= len; n++) begin
      @(negedge clk);
      ea = (n > abort_at) ? idle_v : exp_vec(n, m, lut, 8, 30);
      eb = (n > abort_at) ? idle_v : exp_vec(n, m, lut, 0, 0);
      check($sformatf("A_m%0d_l%0d_c%0d", m, lut, n), w_obs_a, ea);
      check($sformatf("B_m%0d_l%0d_c%0d", m, lut, n), w_obs_b, eb);
      if (n == abort_at) begin
        bus_a.abort = 1'b1; bus_b.abort = 1'b1;
      end
      if (n == restart_at) begin
        bus_a.start = 1'b1; bus_b.start = 1'b1;
      end
      @(posedge clk);
      #1 begin
        bus_a.abort = 1'b0; bus_b.abort = 1'b0;
        bus_a.start = 1'b0; bus_b.start = 1'b0;
      end
    end
    last_mode = m;
  endtask

  task automatic reject_seq(input logic [1:0] m);
    @(negedge clk);
    drive(1'b1, m, 1'($urandom_range(0, 1)), 1'b0);
    @(posedge clk);
    #1 drive(1'b0, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("err_pulse_A", w_obs_a, {2'b00, 1'b1, 11'b0, last_mode});
    check("err_pulse_B", w_obs_b, {2'b00, 1'b1, 11'b0, last_mode});
    @(negedge clk);
    check("err_after_A", w_obs_a, {14'b0, last_mode});
  endtask

  initial begin
    int dmin, ab, rs;
    logic [1:0] m;
    bit lut;

    reset = 1'b1;
    drive(1'b0, 2'd0, 1'b0, 1'b0);
    last_mode = 2'd0;
    repeat (3) @(negedge clk);
    check("in_reset_A", w_obs_a, 16'h0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("post_reset_A", w_obs_a, 16'h0);
    check("post_reset_B", w_obs_b, 16'h0);

    run_seq(2'd1, 1'b1, NONE, 50);
    run_seq(2'd0, 1'b0, NONE, 0);
    reject_seq(2'd2);
    reject_seq(2'd3);
    run_seq(2'd1, 1'b1, 80, 0);
    run_seq(2'd1, 1'b1, NONE, 0);

    for (int r = 0; r < 20; r++) begin
      m    = 2'($urandom_range(0, 1));
      lut  = 1'($urandom_range(0, 1));
      dmin = done_cyc(m, lut, 0, 0);
      ab   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, dmin)) : NONE;
      rs   = ($urandom_range(0, 1) == 0) ?
             int'($urandom_range(1, (ab < dmin) ? ab : dmin)) : 0;
      run_seq(m, lut, ab, rs);
      if ($urandom_range(0, 3) == 0) reject_seq(2'($urandom_range(2, 3)));
    end

    // Asynchronous reset while instance A sits in FETCH
    @(negedge clk);
    drive(1'b1, 2'd1, 1'b0, 1'b0);
    @(posedge clk);
    #1 drive(1'b0, 2'd0, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    check("fetch_before_rst", {15'b0, bus_a.fetch}, 16'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_A", w_obs_a, 16'h0);
    check("rst_async_B", w_obs_b, 16'h0);
    @(negedge clk);
    reset = 1'b0;
    last_mode = 2'd0;
    run_seq(2'd0, 1'b1, NONE, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
